// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain tester.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    TEST,
    DONE
  } state_e;

  localparam int unsigned DEF_CHAIN_LEN = 8;
  localparam int unsigned DEF_PAT_W     = 16;
  localparam int unsigned TOTAL_SHIFTS  = 2 * DEF_CHAIN_LEN + DEF_PAT_W;

  // Ceiling log2, never less than 1 so a one-entry range still gets a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned total_shifts(input int unsigned chain_len,
                                               input int unsigned pat_w);
    return 2 * chain_len + pat_w;
  endfunction

endpackage

// File: rtl/scan_expect_gen.sv
// Combinational drive/expect stream generator for the scan chain tester.
// drive_o is the bit to present on scan-in for the NEXT shift edge, because
// scan-in is registered; expect_o is the bit scan-out must show on the
// current TEST edge.
module scan_expect_gen
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned PAT_W     = DEF_PAT_W,
  parameter int unsigned IDX_W     = 5
) (
  input  logic [PAT_W-1:0] pat_i,
  input  state_e           phase_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             drive_o,
  output logic             expect_o
);

  logic [31:0] idx32;

  // Select the pattern bits for the next drive and the current compare.
  always_comb begin
    idx32    = 32'(idx_i);
    drive_o  = 1'b0;
    expect_o = 1'b0;
    unique case (phase_i)
      FLUSH: begin
        if (idx32 == CHAIN_LEN - 1) drive_o = pat_i[0];
      end
      TEST: begin
        if (idx32 + 1 < PAT_W)
          drive_o = |(pat_i & (PAT_W'(1) << (idx32 + 1)));
        if (idx32 >= CHAIN_LEN)
          expect_o = |(pat_i & (PAT_W'(1) << (idx32 - CHAIN_LEN)));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/scan_chain_tester.sv
// Flush-and-pattern scan chain test controller with mismatch reporting.
module scan_chain_tester
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned PAT_W     = DEF_PAT_W,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned IDX_W    = clog2(CHAIN_LEN + PAT_W)
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  output logic             scan_se,
  output logic             scan_si,
  input  logic             scan_so,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_valid,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam int unsigned TEST_LEN = CHAIN_LEN + PAT_W;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             se_q, se_d;
  logic             si_q, si_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ev_q, ev_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic             drive_bit, expect_bit;

  scan_expect_gen #(
    .CHAIN_LEN(CHAIN_LEN),
    .PAT_W    (PAT_W),
    .IDX_W    (IDX_W)
  ) u_expect (
    .pat_i   (pat_q),
    .phase_i (state_q),
    .idx_i   (idx_q),
    .drive_o (drive_bit),
    .expect_o(expect_bit)
  );

  // State and result registers; reset clears everything including results.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      ev_q    <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      fidx_q  <= fidx_d;
    end
  end

  // Sequencing, compare and result update for each shift edge.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    se_d    = se_q;
    si_d    = si_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    ev_d    = ev_q;
    fidx_d  = fidx_q;
    unique case (state_q)
      IDLE: begin
        se_d = 1'b0;
        si_d = 1'b0;
        if (start) begin
          pat_d   = pattern;
          cnt_d   = '0;
          ev_d    = 1'b0;
          fidx_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          se_d    = 1'b1;
          idx_d   = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        si_d = drive_bit;
        if (32'(idx_q) == CHAIN_LEN - 1) begin
          idx_d   = '0;
          state_d = TEST;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      TEST: begin
        si_d = drive_bit;
        if (scan_so != expect_bit) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (!ev_q) begin
            ev_d   = 1'b1;
            fidx_d = idx_q;
          end
        end
        if (32'(idx_q) == TEST_LEN - 1) begin
          se_d    = 1'b0;
          si_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses the updated count so a final-edge mismatch still fails.
          pass_d  = (cnt_d == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign scan_se       = se_q;
  assign scan_si       = si_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = cnt_q;
  assign err_valid     = ev_q;
  assign first_err_idx = fidx_q;

endmodule
